opf_unit: RTL and testbench

//  Parametrised operand-fetch stage, successor to the decode-stage register file wrapper.

---
 rtl/opf_unit.sv | 116 +++++++++++
 tb/tb_opf_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/opf_unit.sv
// Operand-fetch stage: integer register file, pending-write scoreboard and a
// valid/ready output register feeding EXE, with same-cycle write-back bypass.
`timescale 1ns/1ps

module opf_unit #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [NRD-1:0]      in_rs_en,
  input  logic [NRD*AW-1:0]   in_rs_addr,
  input  logic                in_rd_wr,
  input  logic [AW-1:0]       in_rd_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [NRD*XLEN-1:0] out_rs_data,
  output logic                out_rd_wr,
  output logic [AW-1:0]       out_rd_addr,
  input  logic [NWR-1:0]      wb_en,
  input  logic [NWR*AW-1:0]   wb_addr,
  input  logic [NWR*XLEN-1:0] wb_data
);

  logic [XLEN-1:0]     regs [NREG];
  logic [NREG-1:0]     pending;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      hit;
  logic                hz;
  logic                accept;

  function automatic logic is_zero(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Operand select: later (higher-index) write-back ports override earlier ones.
  always_comb begin
    rs_data = '0;
    hit     = '0;
    hz      = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      rs_data[i*XLEN +: XLEN] = regs[in_rs_addr[i*AW +: AW]];
      for (int j = 0; j < NWR; j++) begin
        if (wb_en[j] && (wb_addr[j*AW +: AW] == in_rs_addr[i*AW +: AW])) begin
          rs_data[i*XLEN +: XLEN] = wb_data[j*XLEN +: XLEN];
          hit[i]                  = 1'b1;
        end
      end
      if (is_zero(in_rs_addr[i*AW +: AW]) || !in_rs_en[i])
        rs_data[i*XLEN +: XLEN] = '0;
      if (in_rs_en[i] && pending[in_rs_addr[i*AW +: AW]] && !hit[i])
        hz = 1'b1;
    end
  end

  assign in_ready = ~rst & ~flush & ~hz & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++)
        regs[k] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wb_en[j] && !is_zero(wb_addr[j*AW +: AW]))
          regs[wb_addr[j*AW +: AW]] <= wb_data[j*XLEN +: XLEN];
      end
    end
  end

  // A new producer's set is applied after the write-back clears so it wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (flush) begin
      pending <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wb_en[j])
          pending[wb_addr[j*AW +: AW]] <= 1'b0;
      end
      if (accept && in_rd_wr && !is_zero(in_rd_addr))
        pending[in_rd_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_rs_data <= '0;
      out_rd_wr   <= 1'b0;
      out_rd_addr <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_rs_data <= rs_data;
      out_rd_wr   <= in_rd_wr;
      out_rd_addr <= in_rd_addr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_opf_unit.sv
// Directed bench for opf_unit: stimulus pushes hand-computed expected outputs into
// a scoreboard queue, a monitor process checks them as the DUT presents them.
`timescale 1ns/1ps

module tb_opf_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rd_wr;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [1:0]  in_rs_en;
  logic [9:0]  in_rs_addr;
  logic        in_rd_wr;
  logic [4:0]  in_rd_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [63:0] out_rs_data;
  logic        out_rd_wr;
  logic [4:0]  out_rd_addr;
  logic [1:0]  wb_en;
  logic [9:0]  wb_addr;
  logic [63:0] wb_data;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  opf_unit dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_rs_en    (in_rs_en),
    .in_rs_addr  (in_rs_addr),
    .in_rd_wr    (in_rd_wr),
    .in_rd_addr  (in_rd_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_rs_data (out_rs_data),
    .out_rd_wr   (out_rd_wr),
    .out_rd_addr (out_rd_addr),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; entered and left 1 ns after a rising edge.
  task automatic apply_stimulus(
    input string name, input logic iv, input logic [31:0] pc, input logic [1:0] rs_en,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic rd_wr, input logic [4:0] rd,
    input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
    input logic [4:0] wa1, input logic [31:0] wd1, input logic ordy, input logic fl,
    input logic exp_ready, input logic [31:0] e0, input logic [31:0] e1);
    in_valid   = iv;
    in_pc      = pc;
    in_rs_en   = rs_en;
    in_rs_addr = {rs2, rs1};
    in_rd_wr   = rd_wr;
    in_rd_addr = rd;
    wb_en      = wen;
    wb_addr    = {wa1, wa0};
    wb_data    = {wd1, wd0};
    out_ready  = ordy;
    flush      = fl;
    @(negedge clk);
    check_output({name, "_in_ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
    if (iv && in_ready)
      sb.push_back('{pc: pc, d0: e0, d1: e1, rd_wr: rd_wr, rd: rd});
    @(posedge clk);
    #1;
    if (fl)
      sb.delete();
    in_valid = 1'b0;
    wb_en    = '0;
    flush    = 1'b0;
  endtask

  // Monitor: a presented instruction must match the scoreboard head, and keeps matching while held.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output: got pc 0x%0h, expected no instruction", out_pc);
      end else begin
        if ({out_pc, out_rs_data[31:0], out_rs_data[63:32], out_rd_wr, out_rd_addr} !== sb[0]) begin
          errors++;
          $display("[TB] FAIL out_pc_%0h: got pc=%0h d0=%0h d1=%0h wr=%0b rd=%0d, expected pc=%0h d0=%0h d1=%0h wr=%0b rd=%0d",
                   sb[0].pc, out_pc, out_rs_data[31:0], out_rs_data[63:32], out_rd_wr, out_rd_addr,
                   sb[0].pc, sb[0].d0, sb[0].d1, sb[0].rd_wr, sb[0].rd);
        end
        if (out_ready)
          void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_rs_en = '0; in_rs_addr = '0;
    in_rd_wr = 1'b0; in_rd_addr = '0; out_ready = 1'b1; wb_en = '0; wb_addr = '0; wb_data = '0;
    #7;
    check_output("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("reset_out_pc", out_pc, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back issue with write-back bypass and rs_en gating.
    apply_stimulus("wb_x5",    0, 32'h000, 2'b00, 0, 0, 0, 0, 2'b01, 5, 32'h1234, 0, 0, 1, 0, 1, 32'h0, 32'h0);
    apply_stimulus("add_x5",   1, 32'h100, 2'b01, 5, 0, 1, 6, 2'b00, 0, 0, 0, 0, 1, 0, 1, 32'h1234, 32'h0);
    apply_stimulus("x5_x0",    1, 32'h104, 2'b11, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 32'h1234, 32'h0);
    apply_stimulus("x6_stall", 1, 32'h108, 2'b10, 5, 6, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    apply_stimulus("x6_byp",   1, 32'h108, 2'b10, 5, 6, 0, 0, 2'b01, 6, 32'h66, 0, 0, 1, 0, 1, 32'h0, 32'h66);

    // RAW stall on x7 until the load port writes it back.
    apply_stimulus("rd_x7",    1, 32'h200, 2'b00, 0, 0, 1, 7, 2'b00, 0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0);
    apply_stimulus("raw_1",    1, 32'h204, 2'b01, 7, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    apply_stimulus("raw_2",    1, 32'h204, 2'b01, 7, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    apply_stimulus("raw_byp",  1, 32'h204, 2'b01, 7, 0, 0, 0, 2'b10, 0, 0, 7, 32'hBEEF, 1, 0, 1, 32'hBEEF, 32'h0);

    // Write-back collision on x3: port 1 wins, both in the bypass and in the file.
    apply_stimulus("coll_byp", 1, 32'h300, 2'b01, 3, 0, 0, 0, 2'b11, 3, 32'hA, 3, 32'hB, 1, 0, 1, 32'hB, 32'h0);
    apply_stimulus("coll_rf",  1, 32'h304, 2'b11, 7, 3, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 32'hBEEF, 32'hB);

    // Backpressure: three held cycles, then the next instruction goes in.
    apply_stimulus("bp_1",     0, 32'h000, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    apply_stimulus("bp_2",     1, 32'h400, 2'b01, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    apply_stimulus("bp_3",     1, 32'h400, 2'b01, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    apply_stimulus("bp_rel",   1, 32'h400, 2'b01, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 32'h1234, 32'h0);

    // Flush kills the held instruction and clears pending x9; x0 never stalls or changes.
    apply_stimulus("rd_x9",    1, 32'h500, 2'b00, 0, 0, 1, 9, 2'b00, 0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0);
    apply_stimulus("x9_hold",  1, 32'h504, 2'b01, 9, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    apply_stimulus("flush",    1, 32'h504, 2'b01, 9, 0, 0, 0, 2'b01, 10, 32'h77, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    check_output("flush_out_valid", {31'd0, out_valid}, 32'd0);
    apply_stimulus("post_fl",  1, 32'h504, 2'b11, 9, 10, 0, 0, 2'b10, 0, 0, 0, 32'hFF, 1, 0, 1, 32'h0, 32'h77);
    apply_stimulus("rd_x0",    1, 32'h50C, 2'b01, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0);
    apply_stimulus("rs_x0",    1, 32'h510, 2'b01, 0, 0, 0, 0, 2'b01, 0, 32'hFF, 0, 0, 1, 0, 1, 32'h0, 32'h0);

    // Mid-stream reset clears the output at once and empties the register file.
    apply_stimulus("pre_rst",  1, 32'h600, 2'b01, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 32'h1234, 32'h0);
    rst = 1'b1;
    #1;
    check_output("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    apply_stimulus("rst_x5x7", 1, 32'h700, 2'b11, 5, 7, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0);
    apply_stimulus("rst_x3x10",1, 32'h704, 2'b11, 3, 10, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0);
    repeat (3) apply_stimulus("idle", 0, 32'h0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0);
    check_output("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
